fp_result_classifier: RTL and testbench
=======================================

# fp_result_classifier

Downstream consumer of the FP multiplier stage. Accepts 32-bit IEEE-754 single-precision products over a valid/ready handshake, classifies each word (zero, subnormal, normal, infinity, quiet NaN, signalling NaN) and buffers word and class in a small FIFO for the next stage. Keeps saturating per-class occurrence counters readable by the bench/scoreboard. Backpressure propagates upstream via `in_ready`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of each per-class counter.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream has a result word.
- `in_ready` out 1: block can accept a word this cycle.
- `in_data` in 32: result word {sign, exp[7:0], mant[22:0]}.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: downstream takes the head this cycle.
- `out_data` out 32: FIFO head word, unmodified.
- `out_class` out 3: class code of the head word.
- `clr_cnt` in 1: synchronous clear of all counters.
- `cnt_sel` in 3: counter select for readout.
- `cnt_value` out CNT_W: selected counter value.

## Operation
- Class codes, from exp = `in_data[30:23]`, mant = `in_data[22:0]`; sign ignored:
  - 0 ZERO: exp=0, mant=0. 1 SUBN: exp=0, mant≠0. 2 NORM: exp 1..254.
  - 3 INF: exp=255, mant=0. 4 QNAN: exp=255, mant[22]=1. 5 SNAN: exp=255, mant[22]=0, mant≠0.
  - Codes 6, 7 never produced.
- Classification is computed on `in_data` at accept time and stored with the word; FIFO entry width is 35 bits.
- FSM, two states:
  - INIT: entered on reset; `in_ready`=0; unconditionally to RUN on the next edge.
  - RUN: `in_ready` = not full; `out_valid` = not empty. Stays in RUN until reset.
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`. Occupancy counter: +1 push only, −1 pop only, unchanged when both or neither occur.
- Full: `in_ready`=0 even if a pop occurs that cycle; no push-through when full.
- Empty: `out_valid`=0; no bypass, so a word pushed into an empty FIFO is visible the next cycle.
- Read and write pointers wrap modulo DEPTH.
- Counters: six counters, one per class. On push, the counter of the pushed class increments by 1 and saturates at 2^CNT_W−1.
- `clr_cnt` zeroes all six counters on the next edge and takes priority over a same-cycle increment; the word pushed that cycle is not counted but is still buffered.
- `cnt_value` is combinational from `cnt_sel`; sel 0..5 selects the matching class counter, sel 6/7 returns 0.
- `in_valid` while `in_ready`=0: no effect; upstream holds the word.
- `out_data`/`out_class` are undefined when `out_valid`=0; the bench must not check them.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_class`=0, all counters 0, FIFO empty, pointers 0, state INIT.
- After `rst` falls: first edge INIT→RUN; `in_ready`=1 from then on.
- Accept-to-`out_valid` latency: 1 cycle when empty.
- Counter reflects a push on `cnt_value` 1 cycle after the accept edge.
- Throughput: one word per cycle with simultaneous push and pop when not full.
- Reset mid-operation: FIFO contents discarded immediately (async) and counters cleared; words in flight are lost, with no partial pop.
- `in_ready` and `out_valid` depend only on registered state; no combinational path from `out_ready` to `in_ready`.

## Test plan
- Reset release, then push 0x3F800000 → after 1 cycle `out_valid`=1, `out_data`=0x3F800000, `out_class`=2; with `cnt_sel`=2, `cnt_value`=1.
- Push 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000, 0x7F800001 with `out_ready`=1 → classes popped in order 0, 1, 3, 4, 5; each counter 0,1,3,4,5 reads 1; `cnt_sel`=6 reads 0.
- Hold `out_ready`=0 and push 5 words at DEPTH=4 → `in_ready`=0 after the 4th accept, 5th word held upstream; one pop → `in_ready`=1 next cycle, 5th accepted, order preserved.
- CNT_W=4, push 0x3F800000 twenty times → NORM counter stops at 15. `clr_cnt` asserted on the same cycle as a push → all counters 0, word still popped.
- Assert `rst` with 3 entries queued → `out_valid`=0 and `in_ready`=0 immediately; after release, one INIT cycle, then `in_ready`=1 and the FIFO is empty.

Source files
------------

// File: rtl/fp_result_classifier.sv
// Classifies IEEE-754 single-precision result words, buffers word+class in a
// small FIFO and keeps saturating per-class occurrence counters.
module fp_result_classifier #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_class,
  input  logic             clr_cnt,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned NCLS  = 6;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUBN = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [OCC_W-1:0]   occ, occ_nxt;
  logic               in_ready_nxt, out_valid_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [31:0]        data_mem [DEPTH];
  logic [2:0]         cls_mem  [DEPTH];
  logic [CNT_W-1:0]   cnt      [NCLS];
  logic [7:0]         in_exp;
  logic [22:0]        in_mant;
  logic [2:0]         in_class;
  logic               push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Class of the incoming word; the sign bit plays no part
  always_comb begin
    in_exp   = in_data[30:23];
    in_mant  = in_data[22:0];
    in_class = CLS_NORM;
    if (in_exp == 8'h00) begin
      in_class = (in_mant == 23'd0) ? CLS_ZERO : CLS_SUBN;
    end else if (in_exp == 8'hFF) begin
      if (in_mant == 23'd0)  in_class = CLS_INF;
      else if (in_mant[22])  in_class = CLS_QNAN;
      else                   in_class = CLS_SNAN;
    end
  end

  // Next state, occupancy and the registered handshake flags
  always_comb begin
    state_nxt     = state;
    occ_nxt       = occ;
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    case (state)
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
    if (push && !pop)      occ_nxt = occ + OCC_W'(1);
    else if (pop && !push) occ_nxt = occ - OCC_W'(1);
    // Flags are registered from next-cycle state, so full blocks input even on a pop
    if (state_nxt == S_RUN) in_ready_nxt = (occ_nxt != OCC_W'(DEPTH));
    out_valid_nxt = (occ_nxt != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      occ       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      occ       <= occ_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // FIFO storage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        cls_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= in_data;
        cls_mem[wr_ptr]  <= in_class;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign out_data  = data_mem[rd_ptr];
  assign out_class = cls_mem[rd_ptr];

  // Saturating per-class counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCLS; i++) cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int unsigned i = 0; i < NCLS; i++) cnt[i] <= '0;
    end else if (push) begin
      for (int unsigned i = 0; i < NCLS; i++) begin
        if (in_class == 3'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_value = '0;
    for (int unsigned i = 0; i < NCLS; i++) begin
      if (cnt_sel == 3'(i)) cnt_value = cnt[i];
    end
  end

endmodule

// File: tb/tb_fp_result_classifier.sv
// Self-checking bench for fp_result_classifier: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fp_result_classifier;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [31:0]      in_data;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [2:0]       out_class;
  logic             clr_cnt;
  logic [2:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_value;

  fp_result_classifier #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class),
    .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] q[$];
  int          cnt_m[6];
  bit          running;

  typedef struct {
    logic [31:0] d;
    int          cls;
  } vec_t;

  function automatic int ref_class(input logic [31:0] d);
    int unsigned e, m;
    e = (d >> 23) & 32'hFF;
    m = d & 32'h7FFFFF;
    if (e == 0)   return (m == 0) ? 0 : 1;
    if (e != 255) return 2;
    if (m == 0)   return 3;
    return (m >= 32'h400000) ? 4 : 5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    running = 0;
  endtask

  task automatic check_all();
    int exp_cnt;
    chk("in_ready", 32'(in_ready), 32'(running && q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0]);
      chk("out_class", 32'(out_class), 32'(ref_class(q[0])));
    end
    exp_cnt = (cnt_sel < 6) ? cnt_m[cnt_sel] : 0;
    chk("cnt_value", 32'(cnt_value), 32'(exp_cnt));
  endtask

  // One clock: predict the handshake from the model, advance it with the DUT
  task automatic tick();
    bit          rdy, vld, do_push, do_pop, do_clr;
    logic [31:0] din;
    int          c;
    rdy     = running && q.size() < DEPTH;
    vld     = q.size() != 0;
    do_push = in_valid && rdy;
    do_pop  = vld && out_ready;
    do_clr  = clr_cnt;
    din     = in_data;
    @(posedge clk);
    if (!rst) begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(din);
      if (do_clr) begin
        foreach (cnt_m[i]) cnt_m[i] = 0;
      end else if (do_push) begin
        c = ref_class(din);
        if (cnt_m[c] < CMAX) cnt_m[c]++;
      end
      running = 1;
    end
    @(negedge clk);
  endtask

  task automatic read_cnt(input string nm, input int sel, input int exp);
    cnt_sel = 3'(sel);
    #1;
    chk(nm, 32'(cnt_value), 32'(exp));
  endtask

  function automatic logic [31:0] gen_word();
    logic        s;
    logic [7:0]  e;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: return {s, 31'd0};
      1: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      2: begin
        e = 8'($urandom_range(1, 254));
        return {s, e, 23'($urandom)};
      end
      3: return {s, 8'hFF, 23'd0};
      4: return {s, 8'hFF, 1'b1, 22'($urandom)};
      5: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[12];
    int          popped[$];
    int          exp_order[5];
    logic [31:0] words[5];
    logic [31:0] seq[5];

    vt[0]  = '{32'h3F800000, 2};  vt[1]  = '{32'h80000000, 0};
    vt[2]  = '{32'h00000001, 1};  vt[3]  = '{32'h007FFFFF, 1};
    vt[4]  = '{32'h00800000, 2};  vt[5]  = '{32'hFF7FFFFF, 2};
    vt[6]  = '{32'h7F800000, 3};  vt[7]  = '{32'hFF800000, 3};
    vt[8]  = '{32'h7FC00000, 4};  vt[9]  = '{32'hFFFFFFFF, 4};
    vt[10] = '{32'h7F800001, 5};  vt[11] = '{32'hFFBFFFFF, 5};

    rst = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; clr_cnt = 0; cnt_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    for (int s = 0; s < 8; s++) read_cnt("rst_cnt", s, 0);

    rst = 1'b0;
    #1;
    chk("init_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("run_in_ready", 32'(in_ready), 32'd1);

    // First word visible one cycle after accept, counter follows
    in_data = 32'h3F800000; in_valid = 1;
    tick();
    in_valid = 0; cnt_sel = 3'd2;
    #1;
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", out_data, 32'h3F800000);
    chk("first_class", 32'(out_class), 32'd2);
    chk("first_cnt", 32'(cnt_value), 32'd1);
    out_ready = 1; tick(); out_ready = 0;

    // Vector table
    foreach (vt[i]) begin
      in_data = vt[i].d; in_valid = 1;
      tick();
      in_valid = 0; cnt_sel = 3'(vt[i].cls);
      #1;
      chk("vec_class", 32'(out_class), 32'(vt[i].cls));
      chk("vec_data", out_data, vt[i].d);
      check_all();
      out_ready = 1; tick(); out_ready = 0;
    end

    // Streaming with out_ready held: pop order and per-class counts
    clr_cnt = 1; tick(); clr_cnt = 0;
    seq = '{32'h80000000, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001};
    exp_order = '{0, 1, 3, 4, 5};
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      in_data = seq[k]; in_valid = 1;
      check_all();
      if (out_valid) popped.push_back(int'(out_class));
      tick();
    end
    in_valid = 0;
    for (int k = 0; k < 10 && out_valid; k++) begin
      popped.push_back(int'(out_class));
      tick();
    end
    out_ready = 0;
    chk("order_len", 32'(popped.size()), 32'd5);
    for (int k = 0; k < 5 && k < popped.size(); k++) chk("order", 32'(popped[k]), 32'(exp_order[k]));
    read_cnt("cnt_zero", 0, 1); read_cnt("cnt_subn", 1, 1);
    read_cnt("cnt_inf", 3, 1);  read_cnt("cnt_qnan", 4, 1);
    read_cnt("cnt_snan", 5, 1); read_cnt("cnt_sel6", 6, 0);
    read_cnt("cnt_norm0", 2, 0);

    // Fill to full, fifth held until a pop frees a slot
    words = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    for (int k = 0; k < 4; k++) begin
      in_data = words[k]; in_valid = 1;
      chk("fill_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = words[4];
    chk("full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_hold", 32'(in_ready), 32'd0);
    chk("full_head", out_data, words[0]);
    out_ready = 1; tick(); out_ready = 0;
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    chk("full_pop_head", out_data, words[1]);
    tick();
    in_valid = 0;
    out_ready = 1;
    for (int k = 1; k < 5; k++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", out_data, words[k]);
      tick();
    end
    out_ready = 0;
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Saturation, then clear colliding with a push
    clr_cnt = 1; tick(); clr_cnt = 0;
    in_data = 32'h3F800000; in_valid = 1; out_ready = 1;
    repeat (20) begin
      check_all();
      tick();
    end
    in_valid = 0; tick(); out_ready = 0;
    read_cnt("sat_norm", 2, CMAX);
    in_data = 32'h00000000; in_valid = 1; clr_cnt = 1;
    tick();
    in_valid = 0; clr_cnt = 0;
    chk("clr_push_valid", 32'(out_valid), 32'd1);
    chk("clr_push_data", out_data, 32'd0);
    for (int s = 0; s < 6; s++) read_cnt("clr_cnt", s, 0);
    out_ready = 1; tick(); out_ready = 0;

    // Reset with entries queued
    for (int k = 0; k < 3; k++) begin
      in_data = words[k]; in_valid = 1; tick();
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_init_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_run_ready", 32'(in_ready), 32'd1);
    chk("mid_empty", 32'(out_valid), 32'd0);
    read_cnt("mid_cnt", 2, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cnt_sel = 3'($urandom_range(0, 7));
      #1;
      check_all();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = gen_word();
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid = 0; clr_cnt = 0; out_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
